// File: rtl/multi_lfo_core_if.sv
// multi_lfo_core_if: per-channel config write port and sample stream of the multi-channel LFO
// Signals: cfg_we/cfg_ch/cfg_inc/cfg_shape/cfg_depth/cfg_en (config write, host -> core),
//          out_valid/out_ch/out_data (sample stream, core -> host), out_ready (host -> core),
//          overrun (sticky tick-during-frame flag, core -> host).
// Modports: master = host / DAC side, slave = LFO core.
interface multi_lfo_core_if #(
  parameter int NCH = 2,
  parameter int PHASE_W = 24,
  parameter int DATA_W = 12,
  parameter int CH_W = (NCH > 1) ? $clog2(NCH) : 1
);
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [PHASE_W-1:0] cfg_inc;
  logic [2:0] cfg_shape;
  logic [2:0] cfg_depth;
  logic cfg_en;
  logic out_valid;
  logic out_ready;
  logic [CH_W-1:0] out_ch;
  logic [DATA_W-1:0] out_data;
  logic overrun;
  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_shape, cfg_depth, cfg_en, out_ready,
    input out_valid, out_ch, out_data, overrun
  );
  modport slave (
    input cfg_we, cfg_ch, cfg_inc, cfg_shape, cfg_depth, cfg_en, out_ready,
    output out_valid, out_ch, out_data, overrun
  );
endinterface

// File: rtl/multi_lfo_core.sv
// multi_lfo_core: NCH-channel LFO engine streaming one sample per channel per tick
// Ports: clk, reset_n (async active-low), tick (sample strobe), sync (zero all phases),
//        bus (multi_lfo_core_if.slave: config write port, valid/ready sample stream, overrun).
// Optional feature: define LFO_SAMPLE_HOLD_EN to build the LFSR-driven sample&hold shape (4);
// without it shape 4 outputs midscale like the reserved shapes.
module multi_lfo_core #(
  parameter int NCH = 2,
  parameter int PHASE_W = 24,
  parameter int DATA_W = 12
) (
  input logic clk,
  input logic reset_n,
  input logic tick,
  input logic sync,
  multi_lfo_core_if.slave bus
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, PRESENT} state_t;
  state_t r_state, w_state_nxt;
  logic [CH_W-1:0] r_ch, w_ch_nxt;
  logic [PHASE_W-1:0] r_phase [NCH];
  logic [PHASE_W-1:0] r_inc [NCH];
  logic [2:0] r_shape [NCH];
  logic [2:0] r_depth [NCH];
  logic r_en [NCH];
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0] r_out_ch;
  logic r_overrun;
  logic w_fire, w_last;
  logic [PHASE_W-1:0] w_phase_nxt;
  logic [DATA_W-1:0] w_p, w_tri, w_raw, w_hold, w_sample;
  logic signed [DATA_W-1:0] w_sgn, w_shf;
  assign bus.out_valid = (r_state == PRESENT);
  assign bus.out_ch = r_out_ch;
  assign bus.out_data = r_out_data;
  assign bus.overrun = r_overrun;
  assign w_fire = (r_state == PRESENT) && bus.out_ready;
  assign w_last = (r_ch == CH_W'(NCH - 1));
  assign w_phase_nxt = r_phase[r_ch] + r_inc[r_ch];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_ch <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch <= w_ch_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt = r_ch;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = tick ? CALC : IDLE;
        w_ch_nxt = tick ? '0 : r_ch;
      end
      CALC: w_state_nxt = PRESENT;
      PRESENT: begin
        w_state_nxt = !w_fire ? PRESENT : w_last ? IDLE : CALC;
        w_ch_nxt = (w_fire && !w_last) ? r_ch + CH_W'(1) : r_ch;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // Raw shape, then depth: flip MSB to two's complement, arithmetic shift, flip back.
  always_comb begin
    w_p = r_phase[r_ch][PHASE_W-1 -: DATA_W];
    w_tri = {w_p[DATA_W-1] ? ~w_p[DATA_W-2:0] : w_p[DATA_W-2:0], 1'b0};
    w_raw = r_shape[r_ch] == 3'd0 ? w_p :
            r_shape[r_ch] == 3'd1 ? ~w_p :
            r_shape[r_ch] == 3'd2 ? w_tri :
            r_shape[r_ch] == 3'd3 ? {DATA_W{w_p[DATA_W-1]}} :
            r_shape[r_ch] == 3'd4 ? w_hold : MID;
    w_sgn = {~w_raw[DATA_W-1], w_raw[DATA_W-2:0]};
    w_shf = w_sgn >>> r_depth[r_ch];
    w_sample = r_en[r_ch] ? {~w_shf[DATA_W-1], w_shf[DATA_W-2:0]} : MID;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_phase[i] <= '0;
        r_inc[i] <= '0;
        r_shape[i] <= '0;
        r_depth[i] <= '0;
        r_en[i] <= 1'b0;
      end
      r_out_data <= MID;
      r_out_ch <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.cfg_we && int'(bus.cfg_ch) < NCH) begin
        r_inc[bus.cfg_ch] <= bus.cfg_inc;
        r_shape[bus.cfg_ch] <= bus.cfg_shape;
        r_depth[bus.cfg_ch] <= bus.cfg_depth;
        r_en[bus.cfg_ch] <= bus.cfg_en;
      end
      if (tick && r_state != IDLE)
        r_overrun <= 1'b1;
      if (r_state == CALC) begin
        r_out_data <= w_sample;
        r_out_ch <= r_ch;
      end
      // sync wins over a same-cycle phase advance.
      if (sync)
        for (int i = 0; i < NCH; i++) r_phase[i] <= '0;
      else if (w_fire && r_en[r_ch])
        r_phase[r_ch] <= w_phase_nxt;
    end
`ifdef LFO_SAMPLE_HOLD_EN
  logic [15:0] r_lfsr;
  logic [DATA_W-1:0] r_hold [NCH];
  logic w_wrap;
  // Unsigned add overflowed exactly when the truncated sum is below the old phase.
  assign w_wrap = w_phase_nxt < r_phase[r_ch];
  assign w_hold = r_hold[r_ch];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_lfsr <= '1;
      for (int i = 0; i < NCH; i++) r_hold[i] <= MID;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[14] ^ r_lfsr[12] ^ r_lfsr[3]};
      if (w_fire && !sync && r_en[r_ch] && w_wrap && r_shape[r_ch] == 3'd4)
        r_hold[r_ch] <= r_lfsr[DATA_W-1:0];
    end
`else
  assign w_hold = MID;
`endif
endmodule

// File: tb/tb_multi_lfo_core.sv
// tb_multi_lfo_core: directed self-checking bench for multi_lfo_core (NCH=2, PHASE_W=24, DATA_W=12)
module tb_multi_lfo_core;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic tick = 1'b0;
  logic sync = 1'b0;
  int checks = 0;
  int failures = 0;
  multi_lfo_core_if #(.NCH(2), .PHASE_W(24), .DATA_W(12)) bus ();
  multi_lfo_core #(.NCH(2), .PHASE_W(24), .DATA_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .sync(sync), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic sy;
    logic [23:0] inc;
    logic [2:0] sh;
    logic [2:0] dp;
    logic [11:0] exp_d;
  } vec_t;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic ch, input logic [23:0] inc, input logic [2:0] sh,
                     input logic [2:0] dp, input logic en);
    bus.cfg_we = 1'b1;
    bus.cfg_ch = ch;
    bus.cfg_inc = inc;
    bus.cfg_shape = sh;
    bus.cfg_depth = dp;
    bus.cfg_en = en;
    cyc();
    bus.cfg_we = 1'b0;
  endtask
  task automatic do_tick(input logic s);
    tick = 1'b1;
    sync = s;
    cyc();
    tick = 1'b0;
    sync = 1'b0;
  endtask
  task automatic pulse_sync();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
  endtask
  task automatic wait_valid(input string nm);
    for (int i = 0; i < 10 && !bus.out_valid; i++) cyc();
    if (!bus.out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: out_valid=%0b required 1", nm, bus.out_valid);
    end
  endtask
  task automatic get_sample(input string nm, output logic [11:0] d, output logic c);
    wait_valid(nm);
    d = bus.out_data;
    c = bus.out_ch;
    cyc();
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 12'h800) begin failures++; $display("FAIL reset_data got=%h exp=800", bus.out_data); end
    checks++;
    if (bus.out_ch !== 1'b0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", bus.out_ch); end
    checks++;
    if (bus.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", bus.overrun); end
    #2 reset_n = 1'b1;
    cyc();
  endtask
  task automatic test_saw();
    logic [11:0] d0, d1, e;
    logic c0, c1;
    cfg(1'b0, 24'h100000, 3'd0, 3'd0, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      do_tick(1'b0);
      get_sample("saw_ch0", d0, c0);
      get_sample("saw_ch1", d1, c1);
      e = 12'(k * 256);
      checks++;
      if (d0 !== e || c0 !== 1'b0) begin failures++; $display("FAIL saw_ch0 frame %0d got=%h ch=%0d exp=%h ch=0", k, d0, c0, e); end
      checks++;
      if (d1 !== 12'h800 || c1 !== 1'b1) begin failures++; $display("FAIL saw_ch1_disabled frame %0d got=%h ch=%0d exp=800 ch=1", k, d1, c1); end
    end
  endtask
  task automatic test_shapes();
    vec_t v [10] = '{
      '{1'b0, 24'h800000, 3'd3, 3'd2, 12'h600},
      '{1'b0, 24'h800000, 3'd3, 3'd2, 12'h9FF},
      '{1'b0, 24'h800000, 3'd3, 3'd2, 12'h600},
      '{1'b1, 24'h400000, 3'd2, 3'd0, 12'h000},
      '{1'b0, 24'h400000, 3'd2, 3'd0, 12'h800},
      '{1'b0, 24'h400000, 3'd2, 3'd0, 12'hFFE},
      '{1'b0, 24'h000000, 3'd1, 3'd0, 12'h3FF},
      '{1'b0, 24'h000000, 3'd1, 3'd1, 12'h5FF},
      '{1'b0, 24'h000000, 3'd5, 3'd0, 12'h800},
      '{1'b0, 24'h000000, 3'd7, 3'd3, 12'h800}
    };
    logic [11:0] d0, d1;
    logic c0, c1;
    for (int k = 0; k < 10; k++) begin
      if (v[k].sy) pulse_sync();
      cfg(1'b0, v[k].inc, v[k].sh, v[k].dp, 1'b1);
      do_tick(1'b0);
      get_sample("shape_ch0", d0, c0);
      get_sample("shape_ch1", d1, c1);
      checks++;
      if (d0 !== v[k].exp_d) begin failures++; $display("FAIL shape row %0d shape=%0d depth=%0d got=%h exp=%h", k, v[k].sh, v[k].dp, d0, v[k].exp_d); end
    end
  endtask
  task automatic test_backpressure();
    logic [11:0] d0, d1;
    logic c0, c1;
    int nvalid;
    cfg(1'b0, 24'h100000, 3'd0, 3'd0, 1'b1);
    pulse_sync();
    bus.out_ready = 1'b0;
    do_tick(1'b0);
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 12'h000 || bus.out_ch !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d got valid=%0b data=%h ch=%0d exp valid=1 data=000 ch=0", i, bus.out_valid, bus.out_data, bus.out_ch);
      end
      if (i == 0) begin
        checks++;
        if (bus.overrun !== 1'b0) begin failures++; $display("FAIL bp_overrun_before got=%0b exp=0", bus.overrun); end
      end
      tick = (i == 1);
      cyc();
      tick = 1'b0;
    end
    checks++;
    if (bus.overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun got=%0b exp=1", bus.overrun); end
    bus.out_ready = 1'b1;
    get_sample("bp_ch0", d0, c0);
    get_sample("bp_ch1", d1, c1);
    checks++;
    if (d1 !== 12'h800 || c1 !== 1'b1) begin failures++; $display("FAIL bp_ch1 got=%h ch=%0d exp=800 ch=1", d1, c1); end
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid) nvalid++;
      cyc();
    end
    checks++;
    if (nvalid !== 0) begin failures++; $display("FAIL bp_no_extra_frame valid_cycles=%0d exp=0", nvalid); end
  endtask
  task automatic test_sync();
    logic [11:0] d0, d1, e;
    logic c0, c1;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      do_tick(1'b0);
      get_sample("sync_pre0", d0, c0);
      get_sample("sync_pre1", d1, c1);
      e = 12'(k * 256);
      checks++;
      if (d0 !== e) begin failures++; $display("FAIL sync_pre frame %0d got=%h exp=%h", k, d0, e); end
    end
    pulse_sync();
    do_tick(1'b0);
    get_sample("sync_after0", d0, c0);
    get_sample("sync_after1", d1, c1);
    checks++;
    if (d0 !== 12'h000) begin failures++; $display("FAIL sync_after got=%h exp=000", d0); end
    do_tick(1'b1);
    get_sample("sync_tick0", d0, c0);
    get_sample("sync_tick1", d1, c1);
    checks++;
    if (d0 !== 12'h000) begin failures++; $display("FAIL sync_with_tick got=%h exp=000", d0); end
    bus.out_ready = 1'b0;
    do_tick(1'b0);
    wait_valid("sync_hs_wait");
    checks++;
    if (bus.out_data !== 12'h100) begin failures++; $display("FAIL sync_hs_pre got=%h exp=100", bus.out_data); end
    sync = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    sync = 1'b0;
    get_sample("sync_hs1", d1, c1);
    do_tick(1'b0);
    get_sample("sync_hs_next0", d0, c0);
    get_sample("sync_hs_next1", d1, c1);
    checks++;
    if (d0 !== 12'h000) begin failures++; $display("FAIL sync_with_handshake got=%h exp=000", d0); end
  endtask
  task automatic test_sample_hold();
    logic [11:0] s [6];
    logic [11:0] d1;
    logic c0, c1;
    pulse_sync();
    cfg(1'b0, 24'h800000, 3'd4, 3'd0, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      do_tick(1'b0);
      get_sample("sh_ch0", s[k], c0);
      get_sample("sh_ch1", d1, c1);
    end
`ifdef LFO_SAMPLE_HOLD_EN
    checks++;
    if (s[0] !== 12'h800 || s[1] !== 12'h800) begin failures++; $display("FAIL sh_initial got=%h,%h exp=800,800", s[0], s[1]); end
    checks++;
    if (s[3] !== s[2]) begin failures++; $display("FAIL sh_hold_pair1 got=%h exp=%h", s[3], s[2]); end
    checks++;
    if (s[5] !== s[4]) begin failures++; $display("FAIL sh_hold_pair2 got=%h exp=%h", s[5], s[4]); end
    checks++;
    if (s[4] === s[2]) begin failures++; $display("FAIL sh_change got=%h exp!=%h", s[4], s[2]); end
`else
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (s[k] !== 12'h800) begin failures++; $display("FAIL sh_disabled frame %0d got=%h exp=800", k, s[k]); end
    end
`endif
  endtask
  task automatic test_reset_midframe();
    logic [11:0] d0, d1;
    logic c0, c1;
    int nvalid;
    cfg(1'b0, 24'h100000, 3'd0, 3'd0, 1'b1);
    cfg(1'b1, 24'h100000, 3'd0, 3'd0, 1'b1);
    pulse_sync();
    bus.out_ready = 1'b1;
    do_tick(1'b0);
    get_sample("rm_ch0", d0, c0);
    bus.out_ready = 1'b0;
    wait_valid("rm_ch1");
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b1 || bus.out_data !== 12'h000 || bus.overrun !== 1'b1) begin
      failures++;
      $display("FAIL rm_pre got valid=%0b ch=%0d data=%h overrun=%0b exp 1,1,000,1", bus.out_valid, bus.out_ch, bus.out_data, bus.overrun);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%0b exp=0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 12'h800) begin failures++; $display("FAIL rm_data got=%h exp=800", bus.out_data); end
    checks++;
    if (bus.out_ch !== 1'b0) begin failures++; $display("FAIL rm_ch got=%0d exp=0", bus.out_ch); end
    checks++;
    if (bus.overrun !== 1'b0) begin failures++; $display("FAIL rm_overrun got=%0b exp=0", bus.overrun); end
    repeat (2) cyc();
    #2 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (bus.out_valid) nvalid++;
    end
    checks++;
    if (nvalid !== 0) begin failures++; $display("FAIL rm_abandoned valid_cycles=%0d exp=0", nvalid); end
    do_tick(1'b0);
    get_sample("rm_post0", d0, c0);
    get_sample("rm_post1", d1, c1);
    checks++;
    if (d0 !== 12'h800 || d1 !== 12'h800) begin failures++; $display("FAIL rm_cfg_cleared got=%h,%h exp=800,800", d0, d1); end
  endtask
  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_ch = 1'b0;
    bus.cfg_inc = '0;
    bus.cfg_shape = '0;
    bus.cfg_depth = '0;
    bus.cfg_en = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    test_reset();
    test_saw();
    test_shapes();
    test_backpressure();
    test_sync();
    test_sample_hold();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout: simulation did not complete, required completion before 200000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multi_lfo_core.md
# multi_lfo_core

Parametrised multi-channel LFO engine and successor to the single-channel wave generator. Each of NCH channels has its own phase accumulator, increment, shape, depth and enable. On every sample tick the block computes one sample per channel and presents them in channel order on a valid/ready stream to the DAC interface. Configuration comes from the encoder/value logic through a per-channel write port.

## Interface
- NCH, 2: channel count, 1..8
- PHASE_W, 24: phase accumulator width, must be ≥ DATA_W+1
- DATA_W, 12: sample width, offset binary, midscale = 2^(DATA_W-1)
- CH_W, max(1,$clog2(NCH)): channel index width (derived)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tick  in  1  sample-rate strobe, one-cycle pulse
- sync  in  1  zero all phase accumulators
- cfg_we  in  1  write config for channel cfg_ch
- cfg_ch  in  CH_W  target channel; writes with cfg_ch ≥ NCH are ignored
- cfg_inc  in  PHASE_W  phase increment per tick
- cfg_shape  in  3  0 saw-up, 1 saw-down, 2 triangle, 3 square, 4 sample&hold, 5-7 reserved
- cfg_depth  in  3  attenuation: arithmetic right shift of the signed sample
- cfg_en  in  1  channel enable
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts
- out_ch  out  CH_W  channel of out_data
- out_data  out  DATA_W  sample
- overrun  out  1  sticky; a tick arrived while a frame was in progress

## Operation
- Reset values: out_valid 0, out_ch 0, out_data midscale (0x800 at DATA_W=12), overrun 0. All phases, incs, shapes, depths and enables are 0. LFSR is all ones. Held S&H values are midscale.
- Config writes apply on the next clk edge, including mid-frame. CALC uses the values present in its cycle.
- FSM states and transitions:
  - IDLE: goes to CALC on tick, with ch=0.
  - CALC: computes and registers out_data/out_ch, then goes to PRESENT.
  - PRESENT: holds out_valid=1. On out_valid&&out_ready, advances the channel's phase. It then goes to CALC with ch+1, or to IDLE after ch=NCH-1.
- Raw sample, where p = phase[PHASE_W-1 -: DATA_W]:
  - saw-up: p
  - saw-down: ~p
  - triangle: p[MSB] ? ~p[MSB-1:0] : p[MSB-1:0], shifted left 1 with LSB 0
  - square: p[MSB] ? all-ones : 0
  - reserved: midscale
- Depth: invert the raw MSB to get two's complement, arithmetic right shift by cfg_depth, then invert the MSB back.
- Disabled channel: presents midscale and its phase does not advance.
- Phase advance: phase ← phase + inc, modulo 2^PHASE_W. The carry out is the wrap event.
- sync: all phases become 0 in that cycle. A phase advance in the same cycle is discarded. sync together with tick in IDLE starts the frame from phase 0.
- tick outside IDLE is ignored and sets overrun. overrun is cleared only by reset.
- Reset mid-frame: outputs return to reset values immediately. The frame is abandoned.

## Timing
- tick sampled in cycle T → CALC at T+1 → out_valid=1 for ch0 at T+2.
- Each handshake → next channel out_valid two cycles later.
- With out_ready held at 1: last handshake at T+2·NCH, IDLE at T+2·NCH+1. A tick is accepted again from that cycle.
- While out_valid=1 and out_ready=0: out_valid, out_ch and out_data are held stable.
- First sample after reset, or after sync, corresponds to phase 0.

## Configuration
- LFO_SAMPLE_HOLD_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,15,13,4) steps every clk.
  - On a phase wrap, a shape-4 channel latches LFSR[DATA_W-1:0] into its held value.
  - Shape 4 outputs the held value, depth-scaled.
- Not defined: shape 4 behaves as reserved (midscale). No LFSR or held registers are synthesised.

## Test plan
- Reset check: assert reset_n low mid-frame → out_valid=0, out_data=0x800, out_ch=0, overrun=0 immediately.
- Saw-up on ch0: inc=0x100000, depth 0, enabled, out_ready=1, 17 ticks → ch0 samples 0x000, 0x100, …, 0xF00, 0x000. ch1 (disabled) presents 0x800 every frame.
- Square on ch0 with depth 2: high half → 0x9FF, low half → 0x600. Triangle with phase top = 0x400 → 0x800.
- Backpressure: out_ready=0 for 5 cycles → outputs stable. A tick during the stall → overrun=1, and no extra frame runs.
- Sync: after 5 ticks of saw-up, pulse sync → next frame ch0=0x000. sync coincident with a handshake → phase stays 0.
- With LFO_SAMPLE_HOLD_EN and inc=0x800000: held value changes only every second tick. Without the macro, shape 4 → 0x800.
